// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight; results return tagged with the issuing requester's ID.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_a,
    input  logic [3:0]         req0_b,
    input  logic [3:0]         req0_sel,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_a,
    input  logic [3:0]         req1_b,
    input  logic [3:0]         req1_sel,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [3:0]         alu_sel,
    input  logic [7:0]         alu_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic               rsp_id,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    localparam int unsigned CntW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [3:0]           alu_a_q, alu_a_d;
    logic [3:0]           alu_b_q, alu_b_d;
    logic [3:0]           alu_sel_q, alu_sel_d;
    logic [7:0]           data_q, data_d;
    logic                 id_q, id_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 accept;
    logic                 grant1;

    // Grant decode; gated by rst so neither ready is seen while reset is held.
    always_comb begin
        accept = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !rst) begin
            accept = req0_valid | req1_valid;
            if (req0_valid && req1_valid) begin
                grant1 = ~last_q;
            end else begin
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = accept & ~grant1;
    assign req1_ready = accept & grant1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        data_d    = data_q;
        id_d      = id_q;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StWait;
                    cnt_d     = CntW'(ALU_LAT);
                    last_d    = grant1;
                    id_d      = grant1;
                    alu_a_d   = grant1 ? req1_a : req0_a;
                    alu_b_d   = grant1 ? req1_b : req0_b;
                    alu_sel_d = grant1 ? req1_sel : req0_sel;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    data_d  = alu_y;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    count_d = count_q + COUNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            data_q    <= '0;
            id_q      <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            data_q    <= data_d;
            id_q      <= id_d;
            count_q   <= count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != StIdle);
    assign op_count  = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: default instance plus a COUNT_W=2, ALU_LAT=3 instance.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default-parameter instance
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic [7:0] alu_y;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;
    logic [15:0] op_count;

    // COUNT_W=2, ALU_LAT=3 instance
    logic       w_rst;
    logic       w_req0_valid, w_req0_ready, w_req1_valid, w_req1_ready;
    logic [3:0] w_req0_a, w_req0_b, w_req0_sel, w_req1_a, w_req1_b, w_req1_sel;
    logic [3:0] w_alu_a, w_alu_b, w_alu_sel;
    logic [7:0] w_alu_y;
    logic       w_rsp_valid, w_rsp_ready, w_rsp_id, w_busy;
    logic [7:0] w_rsp_data;
    logic [1:0] w_op_count;

    alu_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.ALU_LAT(3), .COUNT_W(2)) u_dut_w (
        .clk(clk), .rst(w_rst),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready),
        .req0_a(w_req0_a), .req0_b(w_req0_b), .req0_sel(w_req0_sel),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready),
        .req1_a(w_req1_a), .req1_b(w_req1_b), .req1_sel(w_req1_sel),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sel(w_alu_sel), .alu_y(w_alu_y),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data),
        .rsp_id(w_rsp_id), .busy(w_busy), .op_count(w_op_count)
    );

    // Behavioural ALU: add 0110, mul 0101, and 1010, xor 1100 on sign-extended operands.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
        logic signed [7:0] sa, sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        case (sel)
            4'b0110: return sa + sb;
            4'b0101: return sa * sb;
            4'b1010: return sa & sb;
            4'b1100: return sa ^ sb;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) alu_y <= alu_f(alu_a, alu_b, alu_sel);

    logic [7:0] w_pipe [3];
    always @(posedge clk) begin
        w_pipe[0] <= alu_f(w_alu_a, w_alu_b, w_alu_sel);
        w_pipe[1] <= w_pipe[0];
        w_pipe[2] <= w_pipe[1];
    end
    assign w_alu_y = w_pipe[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rsp_w(output int n);
        n = 0;
        while (!w_rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2; req0_sel = 4'b0110;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_sel = 4'b1010;
        rsp_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_sel} !== 12'h000) begin
            n_err++; $display("FAIL reset_alu: got %h want 000", {alu_a, alu_b, alu_sel});
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, busy, rsp_data, op_count} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v%b id%b busy%b data%h cnt%h want all 0",
                     rsp_valid, rsp_id, busy, rsp_data, op_count);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL reset_first_grant: got %b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        int n;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd2; req0_sel = 4'b0110;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++; $display("FAIL add_ready: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if ({req0_ready, busy, alu_sel, alu_a, alu_b} !== {2'b01, 4'b0110, 4'd3, 4'd2}) begin
            n_err++;
            $display("FAIL add_issue: got rdy%b busy%b sel%b a%h b%h want rdy0 busy1 sel0110 a3 b2",
                     req0_ready, busy, alu_sel, alu_a, alu_b);
        end
        wait_rsp(n);
        n_cmp++;
        if (n !== 2) begin
            n_err++; $display("FAIL add_latency: got %0d want 2", n);
        end
        n_cmp++;
        if ({rsp_data, rsp_id} !== {8'd5, 1'b0}) begin
            n_err++; $display("FAIL add_rsp: got data %h id %b want 05 id 0", rsp_data, rsp_id);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, busy, op_count} !== {2'b00, 16'd1}) begin
            n_err++;
            $display("FAIL add_done: got v%b busy%b cnt%0d want v0 busy0 cnt1",
                     rsp_valid, busy, op_count);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_sel} !== {4'd3, 4'd2, 4'b0110}) begin
            n_err++; $display("FAIL add_hold: got %h want 326", {alu_a, alu_b, alu_sel});
        end
    endtask

    task automatic test_contention();
        int n;
        logic       exp_id;
        logic [7:0] exp_data;
        // Fresh reset so the first tie goes to requester 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'hE; req0_sel = 4'b0101;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_sel = 4'b1010;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id   = (k % 2 == 1);
            exp_data = exp_id ? 8'h01 : 8'hFA;
            n_cmp++;
            if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
                n_err++;
                $display("FAIL contention_grant%0d: got %b want %b", k,
                         {req0_ready, req1_ready}, {~exp_id, exp_id});
            end
            tick();
            wait_rsp(n);
            n_cmp++;
            if ({n[7:0], rsp_data, rsp_id} !== {8'd2, exp_data, exp_id}) begin
                n_err++;
                $display("FAIL contention_rsp%0d: got lat %0d data %h id %b want lat 2 data %h id %b",
                         k, n, rsp_data, rsp_id, exp_data, exp_id);
            end
            tick();
        end
        n_cmp++;
        if (op_count !== 16'd4) begin
            n_err++; $display("FAIL contention_count: got %0d want 4", op_count);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 4'b0110;
        rsp_ready = 1'b0;
        #1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_sel = 4'b1010;
        wait_rsp(n);
        n_cmp++;
        if (n !== 2) begin
            n_err++; $display("FAIL bp_latency: got %0d want 2", n);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_id, req1_ready, op_count} !==
                {1'b1, 8'd2, 1'b0, 1'b0, 16'd4}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v%b data %h id %b r1rdy %b cnt %0d want v1 02 id0 r1rdy0 cnt4",
                         k, rsp_valid, rsp_data, rsp_id, req1_ready, op_count);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_handshake_ready: got %b want 0", req1_ready);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, req1_ready, op_count} !== {2'b01, 16'd5}) begin
            n_err++;
            $display("FAIL bp_after: got v%b r1rdy%b cnt%0d want v0 r1rdy1 cnt5",
                     rsp_valid, req1_ready, op_count);
        end
        tick();
        req1_valid = 1'b0;
        wait_rsp(n);
        n_cmp++;
        if ({n[7:0], rsp_data, rsp_id} !== {8'd2, 8'h01, 1'b1}) begin
            n_err++;
            $display("FAIL bp_req1_rsp: got lat %0d data %h id %b want lat 2 data 01 id 1",
                     n, rsp_data, rsp_id);
        end
        tick();
        n_cmp++;
        if (op_count !== 16'd6) begin
            n_err++; $display("FAIL bp_count: got %0d want 6", op_count);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_sel = 4'b1100;
        rsp_ready = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL midreset_rsp: got %0d valid cycles want 0", seen);
        end
        n_cmp++;
        if ({op_count, alu_a, alu_b, alu_sel, busy} !== 29'd0) begin
            n_err++;
            $display("FAIL midreset_state: got cnt %0d alu %h busy %b want 0 000 0",
                     op_count, {alu_a, alu_b, alu_sel}, busy);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [3:0] va [5];
        logic [3:0] vb [5];
        logic [7:0] vy [5];
        logic [1:0] vc [5];
        va = '{4'd1, 4'd2, 4'hF, 4'd7, 4'h8};
        vb = '{4'd1, 4'd3, 4'hF, 4'd7, 4'h8};
        vy = '{8'h02, 8'h05, 8'hFE, 8'h0E, 8'hF0};
        vc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        tick();
        w_rst = 1'b0;
        w_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w_req0_valid = 1'b1; w_req0_a = va[k]; w_req0_b = vb[k]; w_req0_sel = 4'b0110;
            #1;
            n_cmp++;
            if (w_req0_ready !== 1'b1) begin
                n_err++; $display("FAIL wrap_ready%0d: got %b want 1", k, w_req0_ready);
            end
            tick();
            w_req0_valid = 1'b0;
            wait_rsp_w(n);
            n_cmp++;
            if ({n[7:0], w_rsp_data} !== {8'd4, vy[k]}) begin
                n_err++;
                $display("FAIL wrap_rsp%0d: got lat %0d data %h want lat 4 data %h",
                         k, n, w_rsp_data, vy[k]);
            end
            tick();
            n_cmp++;
            if (w_op_count !== vc[k]) begin
                n_err++; $display("FAIL wrap_count%0d: got %0d want %0d", k, w_op_count, vc[k]);
            end
        end
    endtask

    initial begin
        w_rst = 1'b1;
        w_req0_valid = 1'b0; w_req0_a = '0; w_req0_b = '0; w_req0_sel = '0;
        w_req1_valid = 1'b0; w_req1_a = '0; w_req1_b = '0; w_req1_sel = '0;
        w_rsp_ready = 1'b1;
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
